// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath; optional jal support under `JAL_EN.
// Latency (MEM_READY=1): R/I-type 4, lw 5, sw 4, branch/j/jal 3 cycles. Each MEM_READY=0 cycle stretches FETCH/MEM_READ/MEM_WRITE by one.
module multicycle_main_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OPCODE,
  input  logic [4:0] RT,
  input  logic       MEM_READY,
  output logic       PC_EN,
  output logic       PCWrite_BEQ,
  output logic       PCWrite_BNE,
  output logic       PCWrite_BLEZ,
  output logic       PCWrite_BGTZ,
  output logic       PCWrite_BLTZ,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ILLEGAL_OP
);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP
`ifdef JAL_EN
    , S_JAL
`endif
  } state_t;

  // br bits: {beq, bne, blez, bgtz, bltz}
  typedef struct packed {
    logic       pc_en;
    logic [4:0] br;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  logic   run;
  logic   fetch_go;

  function automatic state_t dispatch(input logic [5:0] op, input logic [4:0] rt);
    state_t s;
    s = S_FETCH;
    case (op)
      OP_RTYPE:                          s = S_R_EXEC;
      OP_LW, OP_SW:                      s = S_MEM_ADDR;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  s = S_BRANCH;
      OP_REGIMM:                         s = (rt == 5'd0) ? S_BRANCH : S_FETCH;
      OP_J:                              s = S_JUMP;
`ifdef JAL_EN
      OP_JAL:                            s = S_JAL;
`endif
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: s = S_I_EXEC;
      default:                           s = S_FETCH;
    endcase
    return s;
  endfunction

  // Moore outputs for a state; the opcode only selects the branch strobe.
  function automatic ctl_t moore(input state_t s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      S_I_EXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      S_I_WB:      c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_source = 2'b01;
        case (op)
          OP_BEQ:    c.br = 5'b10000;
          OP_BNE:    c.br = 5'b01000;
          OP_BLEZ:   c.br = 5'b00100;
          OP_BGTZ:   c.br = 5'b00010;
          OP_REGIMM: c.br = 5'b00001;
          default:   c.br = 5'b00000;
        endcase
      end
      S_JUMP:      begin c.pc_en = 1'b1; c.pc_source = 2'b10; end
`ifdef JAL_EN
      S_JAL: begin
        c.pc_en      = 1'b1;
        c.pc_source  = 2'b10;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:     nxt = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE:    nxt = dispatch(OPCODE, RT);
      S_MEM_ADDR:  nxt = (OPCODE == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = MEM_READY ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = MEM_READY ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    nxt = S_R_WB;
      S_I_EXEC:    nxt = S_I_WB;
      default:     nxt = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_FETCH;
      ctl_q <= moore(S_FETCH, OP_RTYPE);
    end else begin
      state <= nxt;
      ctl_q <= moore(nxt, OPCODE);
    end
  end

  // Gating by RST lets FETCH controls appear as soon as reset drops.
  assign run      = ~RST;
  assign fetch_go = run & (state == S_FETCH) & MEM_READY;

  assign IRWrite      = fetch_go;
  assign PC_EN        = fetch_go | (run & ctl_q.pc_en);
  assign PCWrite_BEQ  = run & ctl_q.br[4];
  assign PCWrite_BNE  = run & ctl_q.br[3];
  assign PCWrite_BLEZ = run & ctl_q.br[2];
  assign PCWrite_BGTZ = run & ctl_q.br[1];
  assign PCWrite_BLTZ = run & ctl_q.br[0];
  assign IorD         = run & ctl_q.iord;
  assign MemRead      = run & ctl_q.mem_read;
  assign MemWrite     = run & ctl_q.mem_write;
  assign RegDst       = {2{run}} & ctl_q.reg_dst;
  assign MemtoReg     = {2{run}} & ctl_q.mem_to_reg;
  assign RegWrite     = run & ctl_q.reg_write;
  assign ALUSrcA      = run & ctl_q.alu_src_a;
  assign ALUSrcB      = {2{run}} & ctl_q.alu_src_b;
  assign ALUOp        = {2{run}} & ctl_q.alu_op;
  assign PCSource     = {2{run}} & ctl_q.pc_source;
  assign ILLEGAL_OP   = run & (state == S_DECODE) & (dispatch(OPCODE, RT) == S_FETCH);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed-vector bench for multicycle_main_control; expected control words are hand-built per state.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] rt;
  logic       mem_ready;
  logic       pc_en, pcw_beq, pcw_bne, pcw_blez, pcw_bgtz, pcw_bltz;
  logic       iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_main_control dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .RT(rt), .MEM_READY(mem_ready),
    .PC_EN(pc_en), .PCWrite_BEQ(pcw_beq), .PCWrite_BNE(pcw_bne),
    .PCWrite_BLEZ(pcw_blez), .PCWrite_BGTZ(pcw_bgtz), .PCWrite_BLTZ(pcw_bltz),
    .IorD(iord), .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
    .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op),
    .PCSource(pc_source), .ILLEGAL_OP(illegal_op)
  );

  always #5 clk = ~clk;

  // {pc_en, beq, bne, blez, bgtz, bltz, iord, mem_read, mem_write, ir_write,
  //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
  logic [22:0] ctl;
  assign ctl = {pc_en, pcw_beq, pcw_bne, pcw_blez, pcw_bgtz, pcw_bltz, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [22:0] mk(input logic pe, input logic [4:0] br, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic [1:0] dst, input logic [1:0] m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] pcs,
                                     input logic ill);
    return {pe, br, io, mr, mw, irw, dst, m2r, rw, asa, asb, aop, pcs, ill};
  endfunction

  logic [22:0] e_zero, e_fetch, e_fetch_r, e_dec, e_dec_ill, e_maddr, e_mread, e_mwb;
  logic [22:0] e_mwrite, e_rex, e_rwb, e_iex, e_iwb, e_jmp, e_jal, e_br;
  logic [5:0]  br_op [5];
  logic [4:0]  br_sel;

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic now_chk(input string tag, input logic [22:0] exp);
    #1;
    check(tag, ctl, exp);
  endtask

  task automatic tick_chk(input string tag, input logic [22:0] exp);
    @(posedge clk);
    #2;
    check(tag, ctl, exp);
  endtask

  initial begin
    e_zero    = '0;
    e_fetch   = mk('0, '0, '0, '1, '0, '0, 2'b00, 2'b00, '0, '0, 2'b01, 2'b00, 2'b00, '0);
    e_fetch_r = mk('1, '0, '0, '1, '0, '1, 2'b00, 2'b00, '0, '0, 2'b01, 2'b00, 2'b00, '0);
    e_dec     = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, 2'b11, 2'b00, 2'b00, '0);
    e_dec_ill = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, 2'b11, 2'b00, 2'b00, '1);
    e_maddr   = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '1, 2'b10, 2'b00, 2'b00, '0);
    e_mread   = mk('0, '0, '1, '1, '0, '0, 2'b00, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0);
    e_mwb     = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b01, '1, '0, 2'b00, 2'b00, 2'b00, '0);
    e_mwrite  = mk('0, '0, '1, '0, '1, '0, 2'b00, 2'b00, '0, '0, 2'b00, 2'b00, 2'b00, '0);
    e_rex     = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '1, 2'b00, 2'b10, 2'b00, '0);
    e_rwb     = mk('0, '0, '0, '0, '0, '0, 2'b01, 2'b00, '1, '0, 2'b00, 2'b00, 2'b00, '0);
    e_iex     = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '1, 2'b10, 2'b11, 2'b00, '0);
    e_iwb     = mk('0, '0, '0, '0, '0, '0, 2'b00, 2'b00, '1, '0, 2'b00, 2'b00, 2'b00, '0);
    e_jmp     = mk('1, '0, '0, '0, '0, '0, 2'b00, 2'b00, '0, '0, 2'b00, 2'b00, 2'b10, '0);
    e_jal     = mk('1, '0, '0, '0, '0, '0, 2'b10, 2'b10, '1, '0, 2'b00, 2'b00, 2'b10, '0);
    br_op[0] = 6'b000100;
    br_op[1] = 6'b000101;
    br_op[2] = 6'b000110;
    br_op[3] = 6'b000111;
    br_op[4] = 6'b000001;

    rst = 1'b1; opcode = 6'b000000; rt = 5'd0; mem_ready = 1'b1;
    tick_chk("rst_hold", e_zero);
    tick_chk("rst_hold2", e_zero);
    rst = 1'b0;
    now_chk("rst_release_fetch", e_fetch_r);

    // lw, no waits
    opcode = 6'b100011;
    tick_chk("lw_decode", e_dec);
    tick_chk("lw_mem_addr", e_maddr);
    tick_chk("lw_mem_read", e_mread);
    tick_chk("lw_mem_wb", e_mwb);
    tick_chk("lw_back_fetch", e_fetch_r);

    // sw with three wait cycles in MEM_WRITE
    opcode = 6'b101011;
    tick_chk("sw_decode", e_dec);
    tick_chk("sw_mem_addr", e_maddr);
    mem_ready = 1'b0;
    tick_chk("sw_wait1", e_mwrite);
    tick_chk("sw_wait2", e_mwrite);
    tick_chk("sw_wait3", e_mwrite);
    mem_ready = 1'b1;
    now_chk("sw_write_done", e_mwrite);
    tick_chk("sw_back_fetch", e_fetch_r);

    // conditional branches: exactly one strobe each
    for (int i = 0; i < 5; i++) begin
      opcode = br_op[i];
      rt     = 5'd0;
      br_sel = 5'b10000 >> i;
      e_br   = mk('0, br_sel, '0, '0, '0, '0, 2'b00, 2'b00, '0, '1, 2'b00, 2'b01, 2'b01, '0);
      tick_chk($sformatf("br%0d_decode", i), e_dec);
      tick_chk($sformatf("br%0d_strobe", i), e_br);
      tick_chk($sformatf("br%0d_fetch", i), e_fetch_r);
    end

    // two-cycle FETCH stall, then an R-type
    mem_ready = 1'b0;
    now_chk("stall1", e_fetch);
    tick_chk("stall2", e_fetch);
    mem_ready = 1'b1;
    now_chk("stall_release", e_fetch_r);
    opcode = 6'b000000;
    tick_chk("r_decode", e_dec);
    tick_chk("r_exec", e_rex);
    tick_chk("r_wb", e_rwb);
    tick_chk("r_fetch", e_fetch_r);

    // ori
    opcode = 6'b001101;
    tick_chk("ori_decode", e_dec);
    tick_chk("ori_exec", e_iex);
    tick_chk("ori_wb", e_iwb);
    tick_chk("ori_fetch", e_fetch_r);

    // illegal opcode, and REGIMM with a non-zero rt
    opcode = 6'b111111;
    tick_chk("ill_decode", e_dec_ill);
    tick_chk("ill_fetch", e_fetch_r);
    opcode = 6'b000001; rt = 5'd1;
    tick_chk("regimm_rt1_decode", e_dec_ill);
    tick_chk("regimm_rt1_fetch", e_fetch_r);
    rt = 5'd0;

    // j
    opcode = 6'b000010;
    tick_chk("j_decode", e_dec);
    tick_chk("j_jump", e_jmp);
    tick_chk("j_fetch", e_fetch_r);

    // jal
    opcode = 6'b000011;
`ifdef JAL_EN
    tick_chk("jal_decode", e_dec);
    tick_chk("jal_exec", e_jal);
`else
    tick_chk("jal_decode_illegal", e_dec_ill);
`endif
    tick_chk("jal_fetch", e_fetch_r);

    // reset while waiting in MEM_READ
    opcode = 6'b100011;
    tick_chk("rlw_decode", e_dec);
    tick_chk("rlw_mem_addr", e_maddr);
    mem_ready = 1'b0;
    tick_chk("rlw_mem_read_wait", e_mread);
    rst = 1'b1;
    now_chk("rst_mid_instr", e_zero);
    tick_chk("rst_mid_hold", e_zero);
    rst = 1'b0;
    now_chk("rst_mid_release", e_fetch);
    mem_ready = 1'b1;
    now_chk("rst_mid_fetch_go", e_fetch_r);
    tick_chk("rst_mid_decode", e_dec);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
